mem_stage_hs: RTL and testbench

//  Parametrised MEM stage of the 5-stage MIPS pipeline, between EXE and WB. Adds LB/LBU/LH/LHU/LW/SB/SH/SW,
//  a req/ack data-memory handshake with variable latency, and a bus-timeout watchdog. It also detects

---
 rtl/mem_stage_hs.sv | 209 ++++++++++++++++++++
 tb/tb_mem_stage_hs.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM stage of the 5-stage MIPS pipeline (between EXE and WB).
// Handles byte/half/word loads and stores over a req/ack data-memory
// handshake with variable latency. A watchdog ends a request that is never
// acknowledged. Misaligned accesses raise AdEL/AdES without touching memory.
// Non-memory instructions complete in the cycle they arrive.
module mem_stage_hs #(
  parameter int SIDE_W   = 86,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MEM_valid,
  input  logic                 MEM_allow_in,
  input  logic [74+SIDE_W:0]   EXE_MEM_bus_r,
  output logic                 dm_req,
  output logic [31:0]          dm_addr,
  output logic [3:0]           dm_wen,
  output logic [31:0]          dm_wdata,
  input  logic                 dm_ack,
  input  logic [31:0]          dm_rdata,
  output logic                 MEM_over,
  output logic [37+SIDE_W:0]   MEM_WB_bus,
  output logic [4:0]           MEM_wdest,
  output logic [1:0]           MEM_exc,
  output logic [31:0]          MEM_badvaddr,
  output logic [31:0]          MEM_pc
);

  localparam int BUS_W = 75 + SIDE_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte-enable pattern for a store of the given size at the given offset.
  function automatic logic [3:0] store_wen(input logic [1:0] size, input logic [1:0] ofs);
    logic [3:0] w;
    case (size)
      2'b00:   w = 4'b0001 << ofs;
      2'b01:   w = ofs[1] ? 4'b1100 : 4'b0011;
      default: w = 4'b1111;
    endcase
    return w;
  endfunction

  // Store data replicated across every lane the access could target.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] sd);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{sd[7:0]}};
      2'b01:   d = {2{sd[15:0]}};
      default: d = sd;
    endcase
    return d;
  endfunction

  // Select the addressed byte/half of the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                               input logic [1:0] ofs, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{ofs, 3'b000} +: 8];
    h = ofs[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   r = {{24{b[7] & ~uns}}, b};
      2'b01:   r = {{16{h[15] & ~uns}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Bus fields
  logic [4:0]        mem_op_s;
  logic [31:0]       store_data_s;
  logic [31:0]       exe_result_s;
  logic              rf_wen_s;
  logic [4:0]        rf_wdest_s;
  logic [SIDE_W-1:0] side_s;

  assign mem_op_s     = EXE_MEM_bus_r[BUS_W-1  -: 5];
  assign store_data_s = EXE_MEM_bus_r[BUS_W-6  -: 32];
  assign exe_result_s = EXE_MEM_bus_r[BUS_W-38 -: 32];
  assign rf_wen_s     = EXE_MEM_bus_r[SIDE_W+5];
  assign rf_wdest_s   = EXE_MEM_bus_r[SIDE_W+4 : SIDE_W];
  assign side_s       = EXE_MEM_bus_r[SIDE_W-1:0];

  logic       is_load_s, is_store_s, is_mem_s, uns_s, misalign_s, go_s;
  logic [1:0] size_s;

  assign is_load_s  = mem_op_s[4];
  assign is_store_s = mem_op_s[3];
  assign size_s     = mem_op_s[2:1];
  assign uns_s      = mem_op_s[0];
  assign is_mem_s   = is_load_s | is_store_s;
  assign misalign_s = ((size_s == 2'b01) && exe_result_s[0]) ||
                      (size_s[1] && (exe_result_s[1:0] != 2'b00));
  assign go_s       = MEM_valid & is_mem_s & ~misalign_s;

  // State
  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [31:0]        cap_r, cap_s;
  logic               err_r, err_s;
  logic               post_rst_r;
  logic               req_s, over_s;
  logic [1:0]         exc_s;
  logic [31:0]        mem_result_s;

  // Next-state and handshake/completion outputs of the memory-access FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    cap_s   = cap_r;
    err_s   = err_r;
    req_s   = 1'b0;
    over_s  = 1'b0;
    exc_s   = 2'b00;
    if (post_rst_r) begin
      // First cycle out of reset: stay quiet so nothing is issued or retired.
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go_s) begin
            req_s = 1'b1;
            if (dm_ack) begin
              cap_s   = load_extract(size_s, uns_s, exe_result_s[1:0], dm_rdata);
              err_s   = 1'b0;
              state_s = ST_DONE;
            end else begin
              cnt_s   = {CNT_W{1'b0}};
              state_s = ST_WAIT;
            end
          end else begin
            over_s = MEM_valid;
            if (MEM_valid && is_mem_s) begin
              exc_s = is_load_s ? 2'b01 : 2'b10;
            end else begin
              exc_s = 2'b00;
            end
          end
        end
        ST_WAIT: begin
          req_s = 1'b1;
          if (!MEM_valid) begin
            state_s = ST_IDLE;
          end else if (dm_ack) begin
            cap_s   = load_extract(size_s, uns_s, exe_result_s[1:0], dm_rdata);
            err_s   = 1'b0;
            state_s = ST_DONE;
          end else if (cnt_r == CNT_LAST) begin
            err_s   = 1'b1;
            state_s = ST_DONE;
          end else begin
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          over_s = 1'b1;
          exc_s  = err_r ? 2'b11 : 2'b00;
          if (!MEM_valid || MEM_allow_in) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // FSM, wait counter and captured load data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      cap_r      <= 32'h0000_0000;
      err_r      <= 1'b0;
      post_rst_r <= 1'b1;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      cap_r      <= cap_s;
      err_r      <= err_s;
      post_rst_r <= 1'b0;
    end
  end

  assign mem_result_s = is_load_s ? cap_r : exe_result_s;

  assign dm_req       = req_s;
  assign dm_addr      = {exe_result_s[31:2], 2'b00};
  assign dm_wen       = (req_s && is_store_s) ? store_wen(size_s, exe_result_s[1:0]) : 4'b0000;
  assign dm_wdata     = store_lanes(size_s, store_data_s);
  assign MEM_over     = over_s;
  assign MEM_exc      = exc_s;
  assign MEM_badvaddr = (exc_s != 2'b00) ? exe_result_s : 32'h0000_0000;
  assign MEM_pc       = side_s[31:0];
  assign MEM_wdest    = rf_wdest_s & {5{MEM_valid}};
  assign MEM_WB_bus   = {rf_wen_s & (exc_s == 2'b00), rf_wdest_s, mem_result_s, side_s};

endmodule

// File: tb/tb_mem_stage_hs.sv
// Self-checking bench for mem_stage_hs: directed cases plus randomized
// transactions checked every cycle against a transaction-level model.
module tb_mem_stage_hs;
  localparam int SIDE_W   = 86;
  localparam int MAX_WAIT = 16;
  localparam int CNT_W    = 5;
  localparam int BUS_W    = 75 + SIDE_W;
  localparam int WB_W     = 38 + SIDE_W;

  logic              clk = 1'b0;
  logic              reset, MEM_valid, MEM_allow_in, dm_ack;
  logic [BUS_W-1:0]  bus;
  logic [31:0]       dm_rdata;
  logic              dm_req, MEM_over;
  logic [31:0]       dm_addr, dm_wdata, MEM_badvaddr, MEM_pc;
  logic [3:0]        dm_wen;
  logic [WB_W-1:0]   MEM_WB_bus;
  logic [4:0]        MEM_wdest;
  logic [1:0]        MEM_exc;

  always #5 clk = ~clk;

  mem_stage_hs #(.SIDE_W(SIDE_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .MEM_valid(MEM_valid), .MEM_allow_in(MEM_allow_in),
    .EXE_MEM_bus_r(bus), .dm_req(dm_req), .dm_addr(dm_addr), .dm_wen(dm_wen),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .MEM_over(MEM_over),
    .MEM_WB_bus(MEM_WB_bus), .MEM_wdest(MEM_wdest), .MEM_exc(MEM_exc),
    .MEM_badvaddr(MEM_badvaddr), .MEM_pc(MEM_pc)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int req_seen = 0;

  // Expected outputs for the current cycle, written by the stimulus.
  logic              e_chk = 1'b0, e_wd_chk = 1'b0, e_exc_chk = 1'b0;
  logic              e_wb_chk = 1'b0, e_res_chk = 1'b0;
  logic              e_req, e_over, e_wen_eff;
  logic [3:0]        e_wen;
  logic [31:0]       e_addr, e_wdata, e_bad, e_res, e_pc;
  logic [1:0]        e_exc;
  logic [4:0]        e_wdest, e_dest;
  logic [SIDE_W-1:0] e_side;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
  endtask

  // Compare process: checks DUT outputs mid-cycle against the expectations.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (e_chk) begin
        if (dm_req === 1'b1) req_seen++;
        chk("dm_req",    64'(dm_req),    64'(e_req));
        chk("MEM_over",  64'(MEM_over),  64'(e_over));
        chk("dm_wen",    64'(dm_wen),    64'(e_wen));
        chk("dm_addr",   64'(dm_addr),   64'(e_addr));
        chk("MEM_wdest", 64'(MEM_wdest), 64'(e_wdest));
        chk("MEM_pc",    64'(MEM_pc),    64'(e_pc));
        if (e_wd_chk) chk("dm_wdata", 64'(dm_wdata), 64'(e_wdata));
        if (e_exc_chk) begin
          chk("MEM_exc",      64'(MEM_exc),      64'(e_exc));
          chk("MEM_badvaddr", 64'(MEM_badvaddr), 64'(e_bad));
        end
        if (e_wb_chk) begin
          chk("wb_rf_wen",  64'(MEM_WB_bus[WB_W-1]),        64'(e_wen_eff));
          chk("wb_dest",    64'(MEM_WB_bus[WB_W-2 -: 5]),   64'(e_dest));
          chk("wb_side_lo", 64'(MEM_WB_bus[63:0]),          64'(e_side[63:0]));
          chk("wb_side_hi", 64'(MEM_WB_bus[SIDE_W-1:64]),   64'(e_side[SIDE_W-1:64]));
        end
        if (e_res_chk) chk("wb_result", 64'(MEM_WB_bus[SIDE_W+31:SIDE_W]), 64'(e_res));
      end
    end
  end

  task automatic expect_done(input logic [1:0] ex, input logic rfw,
                             input logic [31:0] exe, input logic [31:0] res);
    e_req = 1'b0; e_over = 1'b1; e_wen = 4'h0; e_wd_chk = 1'b0;
    e_exc_chk = 1'b1; e_exc = ex; e_bad = (ex != 2'd0) ? exe : 32'h0;
    e_wb_chk = 1'b1; e_wen_eff = rfw && (ex == 2'd0);
    e_res_chk = (ex == 2'd0); e_res = res;
  endtask

  task automatic go_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      MEM_valid = 1'b0; MEM_allow_in = 1'b0; dm_ack = 1'b0; dm_rdata = $urandom;
      e_chk = 1'b1; e_req = 1'b0; e_over = 1'b0; e_wen = 4'h0; e_wdest = 5'd0;
      e_wd_chk = 1'b0; e_exc_chk = 1'b1; e_exc = 2'd0; e_bad = 32'h0;
      e_wb_chk = 1'b0; e_res_chk = 1'b0;
    end
  endtask

  // One instruction through MEM; expectations derived from the ISA rules.
  // ack_at: request cycle index carrying dm_ack (<0 or >MAX_WAIT: never).
  task automatic run_txn(input logic [4:0] op, input logic [31:0] sd, input logic [31:0] exe,
                         input logic [31:0] rd_ack, input int ack_at, input int stall,
                         output logic [31:0] o_res, output logic [3:0] o_wen,
                         output logic [31:0] o_wd, output logic [1:0] o_exc, output int o_req);
    logic ld, st, un, aligned, tmo, rfw;
    int nb, last;
    logic [31:0] mask, lv, wd;
    logic [3:0] wn;
    logic [1:0] ex;
    logic [4:0] dest;
    logic [SIDE_W-1:0] side;
    ld = op[4]; st = op[3]; un = op[0];
    nb = (op[2:1] == 2'd0) ? 1 : (op[2:1] == 2'd1) ? 2 : 4;
    aligned = (int'(exe[1:0]) % nb) == 0;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    wn = (nb == 4) ? 4'hF : 4'(((1 << nb) - 1) << exe[1:0]);
    wd = (nb == 1) ? sd[7:0] * 32'h0101_0101 : (nb == 2) ? sd[15:0] * 32'h0001_0001 : sd;
    lv = (rd_ack >> (8 * exe[1:0])) & mask;
    if (!un && nb < 4 && lv[8 * nb - 1]) lv = lv | ~mask;
    tmo = (ack_at < 0) || (ack_at > MAX_WAIT);
    ex = (!ld && !st) ? 2'd0 : !aligned ? (ld ? 2'd1 : 2'd2) : tmo ? 2'd3 : 2'd0;
    o_res = ld ? lv : exe;
    o_wen = wn; o_wd = wd; o_exc = ex;
    o_req = ((ld || st) && aligned) ? (tmo ? MAX_WAIT + 1 : ack_at + 1) : 0;
    rfw = 1'($urandom); dest = 5'($urandom);
    side = SIDE_W'({$urandom(), $urandom(), $urandom()});

    @(negedge clk);
    bus = {op, sd, exe, rfw, dest, side};
    MEM_valid = 1'b1; MEM_allow_in = 1'b0; dm_ack = 1'b0; dm_rdata = $urandom;
    req_seen = 0;
    e_chk = 1'b1; e_addr = {exe[31:2], 2'b00}; e_wdest = dest; e_pc = side[31:0];
    e_dest = dest; e_side = side; e_wdata = wd;
    if ((ld || st) && aligned) begin
      last = tmo ? MAX_WAIT : ack_at;
      for (int c = 0; c <= last; c++) begin
        if (c > 0) @(negedge clk);
        dm_ack = (c == ack_at);
        dm_rdata = (c == ack_at) ? rd_ack : $urandom;
        e_req = 1'b1; e_over = 1'b0; e_wen = st ? wn : 4'h0; e_wd_chk = st;
        e_exc_chk = 1'b0; e_wb_chk = 1'b0; e_res_chk = 1'b0;
      end
      for (int s = 0; s <= stall; s++) begin
        @(negedge clk);
        dm_ack = 1'b0; dm_rdata = $urandom; MEM_allow_in = (s == stall);
        expect_done(ex, rfw, exe, o_res);
      end
    end else begin
      for (int s = 0; s <= stall; s++) begin
        if (s > 0) @(negedge clk);
        MEM_allow_in = (s == stall);
        expect_done(ex, rfw, exe, o_res);
      end
    end
    chk("req_cycles", 64'(req_seen), 64'(o_req));
  endtask

  // Start an LW that is left waiting, then abort it (valid drop) or reset.
  task automatic break_wait(input logic use_reset);
    logic [SIDE_W-1:0] side;
    side = SIDE_W'({$urandom(), $urandom(), $urandom()});
    @(negedge clk);
    bus = {5'b10100, 32'h0, 32'h0000_0300, 1'b1, 5'd7, side};
    MEM_valid = 1'b1; MEM_allow_in = 1'b0; dm_ack = 1'b0;
    e_chk = 1'b1; e_req = 1'b1; e_over = 1'b0; e_wen = 4'h0; e_addr = 32'h0000_0300;
    e_wdest = 5'd7; e_pc = side[31:0];
    e_wd_chk = 1'b0; e_exc_chk = 1'b0; e_wb_chk = 1'b0; e_res_chk = 1'b0;
    repeat (2) @(negedge clk);
    if (use_reset) reset = 1'b1;
    else MEM_valid = 1'b0;
    e_chk = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    e_chk = 1'b1; e_req = 1'b0; e_over = 1'b0; e_wen = 4'h0;
    e_wdest = use_reset ? 5'd7 : 5'd0;
    e_exc_chk = 1'b1; e_exc = 2'd0; e_bad = 32'h0;
  endtask

  logic [31:0] r_res, r_wd;
  logic [3:0]  r_wen;
  logic [1:0]  r_exc;
  int          r_req;
  logic [4:0]  ops [10];

  initial begin
    ops = '{5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10100,
            5'b01000, 5'b01010, 5'b01100, 5'b00000, 5'b10110};
    reset = 1'b1; MEM_valid = 1'b0; MEM_allow_in = 1'b0; dm_ack = 1'b0;
    dm_rdata = 32'h0; bus = '0;
    e_addr = 32'h0; e_pc = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    e_chk = 1'b1; e_req = 1'b0; e_over = 1'b0; e_wen = 4'h0; e_wdest = 5'd0;
    e_exc_chk = 1'b1; e_exc = 2'd0; e_bad = 32'h0;
    go_idle(2);

    // Directed cases with hand-computed results pinning the model.
    run_txn(5'b10100, 32'h0, 32'h0000_0100, 32'h1234_5678, 0, 0, r_res, r_wen, r_wd, r_exc, r_req);
    chk("pin_lw_res", 64'(r_res), 64'h1234_5678);
    chk("pin_lw_req", 64'(r_req), 64'd1);
    run_txn(5'b10010, 32'h0, 32'h0000_1002, 32'h8001_1234, 3, 1, r_res, r_wen, r_wd, r_exc, r_req);
    chk("pin_lh_res", 64'(r_res), 64'hFFFF_8001);
    chk("pin_lh_req", 64'(r_req), 64'd4);
    run_txn(5'b10011, 32'h0, 32'h0000_1002, 32'h8001_1234, 3, 0, r_res, r_wen, r_wd, r_exc, r_req);
    chk("pin_lhu_res", 64'(r_res), 64'h0000_8001);
    run_txn(5'b01000, 32'h0000_00AB, 32'h0000_0203, 32'h0, 0, 0, r_res, r_wen, r_wd, r_exc, r_req);
    chk("pin_sb_wen", 64'(r_wen), 64'h8);
    chk("pin_sb_wd",  64'(r_wd),  64'hABAB_ABAB);
    run_txn(5'b01010, 32'h1234_CDEF, 32'h0000_0202, 32'h0, 1, 0, r_res, r_wen, r_wd, r_exc, r_req);
    chk("pin_sh_wen", 64'(r_wen), 64'hC);
    chk("pin_sh_wd",  64'(r_wd),  64'hCDEF_CDEF);
    run_txn(5'b10100, 32'h0, 32'h0000_0106, 32'h0, 0, 1, r_res, r_wen, r_wd, r_exc, r_req);
    chk("pin_adel", 64'(r_exc), 64'd1);
    run_txn(5'b01100, 32'h0, 32'h0000_0101, 32'h0, 0, 0, r_res, r_wen, r_wd, r_exc, r_req);
    chk("pin_ades", 64'(r_exc), 64'd2);
    run_txn(5'b10100, 32'h0, 32'h0000_0400, 32'h0, -1, 0, r_res, r_wen, r_wd, r_exc, r_req);
    chk("pin_tmo_exc", 64'(r_exc), 64'd3);
    chk("pin_tmo_req", 64'(r_req), 64'd17);
    run_txn(5'b10100, 32'h0, 32'h0000_0404, 32'hCAFE_F00D, 16, 0, r_res, r_wen, r_wd, r_exc, r_req);
    chk("pin_late_exc", 64'(r_exc), 64'd0);
    go_idle(1);

    // Abort by valid drop, then reset mid-wait; fresh requests afterwards.
    break_wait(1'b0);
    run_txn(5'b10100, 32'h0, 32'h0000_0500, 32'h0BAD_BEEF, 2, 0, r_res, r_wen, r_wd, r_exc, r_req);
    break_wait(1'b1);
    run_txn(5'b10100, 32'h0, 32'h0000_0300, 32'h0, -1, 0, r_res, r_wen, r_wd, r_exc, r_req);
    run_txn(5'b10100, 32'h0, 32'h0000_0600, 32'h5555_AAAA, 1, 0, r_res, r_wen, r_wd, r_exc, r_req);
    go_idle(1);

    // Randomized transactions.
    for (int t = 0; t < 200; t++) begin
      logic [4:0] op;
      logic [31:0] exe;
      int sel, ack_at;
      op = ops[$urandom_range(0, 9)];
      if (op[4:3] == 2'b00) op = {2'b00, 3'($urandom)};
      exe = $urandom;
      if ($urandom_range(0, 1) == 0) exe[1:0] = 2'b00;
      sel = $urandom_range(0, 9);
      ack_at = (sel <= 5) ? sel : (sel == 6) ? 15 : (sel == 7) ? 16 :
               (sel == 8) ? -1 : $urandom_range(6, 14);
      run_txn(op, $urandom, exe, $urandom, ack_at, $urandom_range(0, 2),
              r_res, r_wen, r_wd, r_exc, r_req);
      if ($urandom_range(0, 3) == 0) go_idle(1);
    end
    go_idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
